// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared constants for the I2C slave: FSM state encoding,
//               address field width and ACK/NACK bit values.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // FSM state encoding
    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_addr      = 3'd1;
    localparam logic [2:0] c_st_addr_ack  = 3'd2;
    localparam logic [2:0] c_st_wr_byte   = 3'd3;
    localparam logic [2:0] c_st_wr_ack    = 3'd4;
    localparam logic [2:0] c_st_rd_byte   = 3'd5;
    localparam logic [2:0] c_st_rd_ack    = 3'd6;
    localparam logic [2:0] c_st_wait_stop = 3'd7;

    // Address field is one bit shorter than a byte (the R/W bit)
    localparam int I2C_BYTE_SIZE = 8;
    localparam int I2C_ADDR_W    = I2C_BYTE_SIZE - 1;

    // Bus value of the acknowledge bit
    localparam logic c_ack_bit  = 1'b0;
    localparam logic c_nack_bit = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_if
// Description : Parallel application-side interface of the I2C slave.
//   tx_data  : read payload presented to the slave
//   rx_data  : last complete write payload
//   rx_valid : 1-cycle pulse, new rx_data
//   rd_done  : 1-cycle pulse, read transaction finished
//   busy     : address-matched transaction in progress
//   byte_cnt : bytes moved in current/last transaction
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_if #(
    parameter int NUM_BYTE   = 4,
    parameter int BYTE_SIZE  = 8,
    parameter int DATA_WIDTH = NUM_BYTE * BYTE_SIZE
);
    localparam int c_cnt_w = $clog2(NUM_BYTE + 1);

    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rd_done;
    logic                  busy;
    logic [c_cnt_w-1:0]    byte_cnt;

    modport slave  (input  tx_data, output rx_data, rx_valid, rd_done, busy, byte_cnt);
    modport master (output tx_data, input  rx_data, rx_valid, rd_done, busy, byte_cnt);
endinterface
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : Two-flop synchronisers plus history flop for SCL and SDA;
//               derives SCL edges and START/STOP bus conditions.
//   clk, reset          : system clock, synchronous active-high reset
//   scl_in, sda_in      : raw bus pins
//   scl_rise, scl_fall  : synchronised SCL edge strobes
//   start_det, stop_det : SDA fall / rise while SCL stays high
//   sda_s               : synchronised SDA
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    // [0] metastability flop, [1] synchronised value, [2] history
    logic [2:0] r_scl_pipe;
    logic [2:0] r_sda_pipe;

    // Reset to the idle-bus level so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_pipe <= '1;
            r_sda_pipe <= '1;
        end else begin
            r_scl_pipe <= {r_scl_pipe[1:0], scl_in};
            r_sda_pipe <= {r_sda_pipe[1:0], sda_in};
        end
    end

    assign sda_s     = r_sda_pipe[1];
    assign scl_rise  =  r_scl_pipe[1] & ~r_scl_pipe[2];
    assign scl_fall  = ~r_scl_pipe[1] &  r_scl_pipe[2];
    assign start_det =  r_scl_pipe[1] &  r_scl_pipe[2] &  r_sda_pipe[2] & ~r_sda_pipe[1];
    assign stop_det  =  r_scl_pipe[1] &  r_scl_pipe[2] & ~r_sda_pipe[2] &  r_sda_pipe[1];
endmodule
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : Clocked I2C slave with one 7-bit address. Writes of NUM_BYTE
//               bytes land in rx_data; reads stream tx_data out MSB-first.
//   clk, reset : system clock (>= 20x SCL), synchronous active-high reset
//   i2c_SCL    : bus clock input (never stretched)
//   i2c_SDA    : open-drain bus data, driven 0 or released
//   app        : parallel data/status interface (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h3C,
    parameter int NUM_BYTE   = 4,
    parameter int BYTE_SIZE  = 8,
    parameter int DATA_WIDTH = NUM_BYTE * BYTE_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i2c_SCL,
    inout  wire          i2c_SDA,
    i2c_slave_if.slave   app
);
    localparam int c_cnt_w = $clog2(NUM_BYTE + 1);
    localparam int c_bit_w = $clog2(BYTE_SIZE + 1);
    localparam logic [c_cnt_w-1:0] c_num_byte  = c_cnt_w'(NUM_BYTE);
    localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(NUM_BYTE - 1);
    localparam logic [c_bit_w-1:0] c_bits      = c_bit_w'(BYTE_SIZE);

    logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

    logic [2:0]            r_state;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [c_cnt_w-1:0]    r_byte_cnt;
    logic [BYTE_SIZE-1:0]  r_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_stage;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_fall_d;   // one cycle after SCL fall: SDA update slot
    logic                  r_sda_low;
    logic                  r_rd;
    logic                  r_wr_xfer;  // write in progress that may still publish
    logic                  r_rx_valid, r_rd_done, r_busy;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (i2c_SCL),
        .sda_in    (i2c_SDA),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start_det),
        .stop_det  (w_stop_det),
        .sda_s     (w_sda_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_tx_shift <= '0;
            r_stage    <= '0;
            r_rx_data  <= '0;
            r_fall_d   <= 1'b0;
            r_sda_low  <= 1'b0;
            r_rd       <= 1'b0;
            r_wr_xfer  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_fall_d   <= w_scl_fall;
            r_rx_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            // Bus conditions win over any bit activity in the same cycle
            if (w_start_det || w_stop_det) begin
                if (r_wr_xfer && (r_byte_cnt == c_num_byte)) begin
                    r_rx_data  <= r_stage;
                    r_rx_valid <= 1'b1;
                end
                r_wr_xfer <= 1'b0;
                r_sda_low <= 1'b0;
                r_bit_cnt <= '0;
                if (w_start_det) begin
                    r_state    <= c_st_addr;
                    r_byte_cnt <= '0;
                end else begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            end else begin
                case (r_state)
                    c_st_addr: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[BYTE_SIZE-2:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (r_fall_d && (r_bit_cnt == c_bits)) begin
                            if (r_shift[BYTE_SIZE-1:1] == SLAVE_ADDR) begin
                                r_state    <= c_st_addr_ack;
                                r_sda_low  <= ~c_ack_bit;
                                r_busy     <= 1'b1;
                                r_rd       <= r_shift[0];
                                r_wr_xfer  <= ~r_shift[0];
                                r_tx_shift <= app.tx_data;
                            end else begin
                                r_state <= c_st_wait_stop;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    // ACK is already on the bus; its SCL rise hands over to the
                    // data phase, whose first fall slot releases or drives SDA.
                    c_st_addr_ack, c_st_wr_ack: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= '0;
                            r_state   <= (r_state == c_st_addr_ack && r_rd) ? c_st_rd_byte
                                                                            : c_st_wr_byte;
                        end
                    end
                    c_st_wr_byte: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[BYTE_SIZE-2:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (r_fall_d) begin
                            r_sda_low <= 1'b0;
                            if (r_bit_cnt == c_bits) begin
                                if (r_byte_cnt < c_num_byte) begin
                                    for (int i = 0; i < NUM_BYTE; i++) begin
                                        if (r_byte_cnt == c_cnt_w'(i))
                                            r_stage[DATA_WIDTH-1-i*BYTE_SIZE -: BYTE_SIZE] <= r_shift;
                                    end
                                    r_byte_cnt <= r_byte_cnt + 1'b1;
                                    r_sda_low  <= ~c_ack_bit;
                                    r_state    <= c_st_wr_ack;
                                end else begin
                                    // Overrun: NACK and never publish this write
                                    r_sda_low <= ~c_nack_bit;
                                    r_wr_xfer <= 1'b0;
                                    r_state   <= c_st_wait_stop;
                                end
                            end
                        end
                    end
                    c_st_rd_byte: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (r_fall_d) begin
                            if (r_bit_cnt == '0) begin
                                r_sda_low <= ~r_tx_shift[DATA_WIDTH-1];
                            end else begin
                                // Eighth shift leaves the next byte's MSB on top
                                r_tx_shift <= r_tx_shift << 1;
                                if (r_bit_cnt == c_bits) begin
                                    r_sda_low <= 1'b0;
                                    r_state   <= c_st_rd_ack;
                                end else begin
                                    r_sda_low <= ~r_tx_shift[DATA_WIDTH-2];
                                end
                            end
                        end
                    end
                    c_st_rd_ack: begin
                        if (w_scl_rise) begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_bit_cnt  <= '0;
                            if ((w_sda_s == c_ack_bit) && (r_byte_cnt < c_last_byte)) begin
                                r_state <= c_st_rd_byte;
                            end else begin
                                r_state   <= c_st_wait_stop;
                                r_rd_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i2c_SDA      = r_sda_low ? 1'b0 : 1'bz;
    assign app.rx_data  = r_rx_data;
    assign app.rx_valid = r_rx_valid;
    assign app.rd_done  = r_rd_done;
    assign app.busy     = r_busy;
    assign app.byte_cnt = r_byte_cnt;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Directed bit-banged I2C master exercising i2c_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;
    localparam int Q = 10;   // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    int n_vec = 0;
    int n_err = 0;
    int n_rxv = 0;
    int n_rdd = 0;

    always #5 clk = ~clk;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_if #(.NUM_BYTE(4), .BYTE_SIZE(8)) app_if ();

    i2c_slave #(
        .SLAVE_ADDR (7'h3C),
        .NUM_BYTE   (4),
        .BYTE_SIZE  (8),
        .DATA_WIDTH (32)
    ) dut (
        .clk     (clk),
        .reset   (rst),
        .i2c_SCL (m_scl),
        .i2c_SDA (sda),
        .app     (app_if)
    );

    always @(negedge clk) begin
        if (app_if.rx_valid) n_rxv++;
        if (app_if.rd_done)  n_rdd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_q();
        m_scl     = 1'b1; wait_q();
        m_sda_low = 1'b1; wait_q();
        m_scl     = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_q();
        m_scl     = 1'b1; wait_q();
        m_sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda_low = ~b; wait_q();
        m_scl     = 1'b1; wait_q();
        s = (sda !== 1'b0);
        wait_q();
        m_scl     = 1'b0; wait_q();
    endtask

    // Returns 1 when the slave pulled SDA low in the ninth clock
    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    // START, address byte, n data bytes (taken MSB-first from d); no STOP.
    // acks[0] is the address ACK, acks[i+1] the ACK of data byte i.
    task automatic wr_seq(input logic [7:0] ab, input int n, input logic [39:0] d,
                          output logic [5:0] acks);
        logic a;
        acks = '0;
        i2c_start();
        wr_byte(ab, a); acks[0] = a;
        for (int i = 0; i < n; i++) begin
            wr_byte(d[39-8*i -: 8], a);
            acks[i+1] = a;
        end
    endtask

    // Reads n bytes, ACKing all but the last; rel = SDA level in the NACK clock
    task automatic rd_seq(input int n, output logic [31:0] d, output logic rel);
        logic s;
        d = '0;
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                clk_bit(1'b1, s);
                d[31-8*k-(7-i)] = s;
            end
            clk_bit((k == n - 1), s);
        end
        rel = s;
    endtask

    initial begin
        logic [5:0]  acks;
        logic [31:0] rd;
        logic        rel;
        logic        s;
        logic [7:0]  ab;

        app_if.tx_data = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        chk("rst_rx_data",  app_if.rx_data, 32'h0);
        chk("rst_busy",     {31'b0, app_if.busy}, 32'h0);
        chk("rst_byte_cnt", {29'b0, app_if.byte_cnt}, 32'h0);
        chk("rst_sda",      {31'b0, (sda !== 1'b0)}, 32'h1);

        // Full write
        wr_seq(8'h78, 4, 40'hA1B2C3D400, acks);
        chk("wr_busy", {31'b0, app_if.busy}, 32'h1);
        i2c_stop();
        chk("wr_acks",     {26'b0, acks}, 32'h1F);
        chk("wr_rx_data",  app_if.rx_data, 32'hA1B2C3D4);
        chk("wr_rx_valid", n_rxv, 1);
        chk("wr_byte_cnt", {29'b0, app_if.byte_cnt}, 32'd4);
        chk("wr_busy_end", {31'b0, app_if.busy}, 32'h0);

        // Address mismatch (0x3D)
        wr_seq(8'h7A, 0, 40'h0, acks);
        chk("mis_ack",  {26'b0, acks}, 32'h0);
        chk("mis_busy", {31'b0, app_if.busy}, 32'h0);
        i2c_stop();
        chk("mis_rx_data", app_if.rx_data, 32'hA1B2C3D4);

        // Read; tx_data changes after the address ACK must not leak in
        app_if.tx_data = 32'h12345678;
        wr_seq(8'h79, 0, 40'h0, acks);
        app_if.tx_data = 32'hDEADBEEF;
        rd_seq(4, rd, rel);
        chk("rd_addr_ack", {26'b0, acks}, 32'h1);
        chk("rd_data",     rd, 32'h12345678);
        chk("rd_released", {31'b0, rel}, 32'h1);
        i2c_stop();
        chk("rd_done",     n_rdd, 1);
        chk("rd_byte_cnt", {29'b0, app_if.byte_cnt}, 32'd4);

        // Partial write: 2 bytes
        wr_seq(8'h78, 2, 40'h1122000000, acks);
        i2c_stop();
        chk("part_acks",     {26'b0, acks}, 32'h07);
        chk("part_rx_valid", n_rxv, 1);
        chk("part_rx_data",  app_if.rx_data, 32'hA1B2C3D4);
        chk("part_byte_cnt", {29'b0, app_if.byte_cnt}, 32'd2);

        // Overrun: 5 bytes, fifth NACKed
        wr_seq(8'h78, 5, 40'h0102030405, acks);
        i2c_stop();
        chk("ovr_acks",     {26'b0, acks}, 32'h1F);
        chk("ovr_rx_valid", n_rxv, 1);
        chk("ovr_rx_data",  app_if.rx_data, 32'hA1B2C3D4);

        // Write one byte, repeated START, read
        app_if.tx_data = 32'hCAFEF00D;
        wr_seq(8'h78, 1, 40'h5500000000, acks);
        chk("rs_wr_acks", {26'b0, acks}, 32'h03);
        chk("rs_sda_free", {31'b0, (sda !== 1'b0)}, 32'h1);
        wr_seq(8'h79, 0, 40'h0, acks);
        rd_seq(4, rd, rel);
        i2c_stop();
        chk("rs_rd_ack",    {26'b0, acks}, 32'h1);
        chk("rs_rd_data",   rd, 32'hCAFEF00D);
        chk("rs_rx_valid",  n_rxv, 1);
        chk("rs_rx_data",   app_if.rx_data, 32'hA1B2C3D4);
        chk("rs_rd_done",   n_rdd, 2);

        // Reset while the slave holds the address ACK low
        i2c_start();
        ab = 8'h78;
        for (int i = 7; i >= 0; i--) clk_bit(ab[i], s);
        m_sda_low = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        chk("rr_ack_low", {31'b0, (sda !== 1'b0)}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_sda_rel", {31'b0, (sda !== 1'b0)}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rr_rx_data",  app_if.rx_data, 32'h0);
        chk("rr_busy",     {31'b0, app_if.busy}, 32'h0);
        chk("rr_byte_cnt", {29'b0, app_if.byte_cnt}, 32'h0);
        wait_q();
        m_scl = 1'b0; wait_q();
        i2c_stop();

        wr_seq(8'h78, 4, 40'h0F1E2D3C00, acks);
        i2c_stop();
        chk("post_acks",     {26'b0, acks}, 32'h1F);
        chk("post_rx_data",  app_if.rx_data, 32'h0F1E2D3C);
        chk("post_rx_valid", n_rxv, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no end, expected summary");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
